// File: rtl/rip_branch_resolver_pkg.sv
// Shared configuration and branch-predictor types for the branch resolver slice.
// Depth defaults live in rip_config; predictor encodings and helpers live in rip_branch_predictor_const.
package rip_config;
    localparam int BP_FIFO_DEPTH = 4;
endpackage

package rip_branch_predictor_const;
    localparam int BP_INDEX_W = 10;

    typedef logic [BP_INDEX_W-1:0] bp_index_t;
    typedef logic [1:0]            bp_weight_t;

    // 2-bit saturating counter encodings (MSB = predicted direction)
    localparam bp_weight_t BP_STRONG_NT = 2'b00;
    localparam bp_weight_t BP_WEAK_NT   = 2'b01;
    localparam bp_weight_t BP_WEAK_T    = 2'b10;
    localparam bp_weight_t BP_STRONG_T  = 2'b11;

    typedef struct packed {
        logic [31:0] pc;
        bp_index_t   index;
        bp_weight_t  weight;
        logic        pred;
        logic [31:0] target;
    } bp_meta_t;

    // A taken branch that was predicted taken still mispredicts if it went somewhere else
    function automatic logic bp_is_mispredict(input bp_meta_t m, input logic taken,
                                              input logic [31:0] target);
        return (m.pred != taken) || (taken && m.pred && (m.target != target));
    endfunction

    function automatic logic [31:0] bp_correct_pc(input bp_meta_t m, input logic taken,
                                                  input logic [31:0] target);
        return taken ? target : (m.pc + 32'd4);
    endfunction
endpackage

// File: rtl/rip_branch_resolver_meta_fifo.sv
// Flop-based in-order FIFO of branch prediction metadata with a combinational head
// and a single-cycle clear used to squash wrong-path entries.
module rip_bp_meta_fifo
    import rip_branch_predictor_const::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     push,
    input  bp_meta_t push_data,
    input  logic     pop,
    input  logic     clear,
    output logic     full,
    output logic     empty,
    output bp_meta_t head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    bp_meta_t         mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_reg[rd_ptr_reg];

    // Payload flops carry no reset; only the pointers decide what is valid
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    // Power-of-two depth lets the pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/rip_branch_resolver.sv
// Matches execute-stage branch outcomes against queued predictions, drives the
// predictor update strobe, raises redirects on mispredicts and keeps statistics.
module rip_branch_resolver
    import rip_config::*;
    import rip_branch_predictor_const::*;
#(
    parameter int FIFO_DEPTH = BP_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        push_valid,
    input  logic [31:0] push_pc,
    input  bp_index_t   push_index,
    input  bp_weight_t  push_weight,
    input  logic        push_pred,
    input  logic [31:0] push_target,
    output logic        full,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        update,
    output bp_index_t   update_index,
    output bp_weight_t  update_weight,
    output logic        actual,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic        underflow,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);
    bp_meta_t    push_data;
    bp_meta_t    head;
    logic        empty;
    logic        fire;
    logic        mispredict_now;
    logic        underflow_now;
    logic        push_en;

    logic        update_reg,        update_next;
    bp_index_t   update_index_reg,  update_index_next;
    bp_weight_t  update_weight_reg, update_weight_next;
    logic        actual_reg,        actual_next;
    logic        mispredict_reg,    mispredict_next;
    logic [31:0] redirect_pc_reg,   redirect_pc_next;
    logic        underflow_reg;
    logic [31:0] branch_count_reg;
    logic [31:0] mispredict_count_reg;

    assign push_data = '{pc: push_pc, index: push_index, weight: push_weight,
                         pred: push_pred, target: push_target};

    assign fire           = ex_valid & ~ex_stall & ~empty;
    assign underflow_now  = ex_valid & ~ex_stall & empty;
    assign mispredict_now = fire & bp_is_mispredict(head, ex_taken, ex_target);
    // A fetch arriving alongside a redirect is on the wrong path
    assign push_en        = push_valid & ~full & ~mispredict_now;

    rip_bp_meta_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_meta_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push_en),
        .push_data(push_data),
        .pop      (fire),
        .clear    (mispredict_now),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

    always_comb begin
        update_next        = fire;
        update_index_next  = '0;
        update_weight_next = '0;
        actual_next        = 1'b0;
        mispredict_next    = mispredict_now;
        redirect_pc_next   = '0;
        if (fire) begin
            update_index_next  = head.index;
            update_weight_next = head.weight;
            actual_next        = ex_taken;
        end
        if (mispredict_now) begin
            redirect_pc_next = bp_correct_pc(head, ex_taken, ex_target);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            update_reg           <= 1'b0;
            update_index_reg     <= '0;
            update_weight_reg    <= '0;
            actual_reg           <= 1'b0;
            mispredict_reg       <= 1'b0;
            redirect_pc_reg      <= '0;
            underflow_reg        <= 1'b0;
            branch_count_reg     <= '0;
            mispredict_count_reg <= '0;
        end else begin
            update_reg        <= update_next;
            update_index_reg  <= update_index_next;
            update_weight_reg <= update_weight_next;
            actual_reg        <= actual_next;
            mispredict_reg    <= mispredict_next;
            redirect_pc_reg   <= redirect_pc_next;
            underflow_reg     <= underflow_reg | underflow_now;
            if (fire && (branch_count_reg != 32'hFFFF_FFFF)) begin
                branch_count_reg <= branch_count_reg + 32'd1;
            end
            if (mispredict_now && (mispredict_count_reg != 32'hFFFF_FFFF)) begin
                mispredict_count_reg <= mispredict_count_reg + 32'd1;
            end
        end
    end

    assign update           = update_reg;
    assign update_index     = update_index_reg;
    assign update_weight    = update_weight_reg;
    assign actual           = actual_reg;
    assign mispredict       = mispredict_reg;
    assign redirect_pc      = redirect_pc_reg;
    assign underflow        = underflow_reg;
    assign branch_count     = branch_count_reg;
    assign mispredict_count = mispredict_count_reg;
endmodule

// File: tb/tb_rip_branch_resolver.sv
// Directed and randomized checks of rip_branch_resolver against a queue-based
// model of in-flight branches.
module tb_rip_branch_resolver;
    import rip_branch_predictor_const::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rstn;
    logic        push_valid;
    logic [31:0] push_pc;
    bp_index_t   push_index;
    bp_weight_t  push_weight;
    logic        push_pred;
    logic [31:0] push_target;
    logic        full;
    logic        ex_valid;
    logic        ex_stall;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        update;
    bp_index_t   update_index;
    bp_weight_t  update_weight;
    logic        actual;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        underflow;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    rip_branch_resolver #(.FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .push_valid      (push_valid),
        .push_pc         (push_pc),
        .push_index      (push_index),
        .push_weight     (push_weight),
        .push_pred       (push_pred),
        .push_target     (push_target),
        .full            (full),
        .ex_valid        (ex_valid),
        .ex_stall        (ex_stall),
        .ex_taken        (ex_taken),
        .ex_target       (ex_target),
        .update          (update),
        .update_index    (update_index),
        .update_weight   (update_weight),
        .actual          (actual),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .underflow       (underflow),
        .branch_count    (branch_count),
        .mispredict_count(mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        bp_index_t   index;
        bp_weight_t  weight;
        logic        pred;
        logic [31:0] target;
    } branch_t;

    branch_t     model_q[$];
    int          checks = 0;
    int          errors = 0;

    logic        exp_update;
    logic [31:0] exp_index;
    logic [31:0] exp_weight;
    logic        exp_actual;
    logic        exp_mis;
    logic [31:0] exp_redirect;
    logic        exp_underflow = 1'b0;
    logic [31:0] exp_bc = '0;
    logic [31:0] exp_mc = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply the current inputs for one clock and compare registered outputs after the edge
    task automatic step();
        branch_t h;
        bit      fire;
        bit      pushed;
        check_val("full", {31'd0, full}, {31'd0, model_q.size() == DEPTH});
        exp_update   = 1'b0;
        exp_index    = '0;
        exp_weight   = '0;
        exp_actual   = 1'b0;
        exp_mis      = 1'b0;
        exp_redirect = '0;
        if (!rstn) begin
            model_q.delete();
            exp_underflow = 1'b0;
            exp_bc        = '0;
            exp_mc        = '0;
        end else begin
            fire   = ex_valid && !ex_stall && (model_q.size() > 0);
            pushed = push_valid && (model_q.size() < DEPTH);
            if (ex_valid && !ex_stall && model_q.size() == 0) exp_underflow = 1'b1;
            if (fire) begin
                h          = model_q[0];
                exp_update = 1'b1;
                exp_index  = 32'(h.index);
                exp_weight = 32'(h.weight);
                exp_actual = ex_taken;
                exp_mis    = (h.pred != ex_taken) || (ex_taken && h.target != ex_target);
                if (exp_mis) exp_redirect = ex_taken ? ex_target : h.pc + 32'd4;
                if (exp_bc != 32'hFFFF_FFFF) exp_bc = exp_bc + 1;
                if (exp_mis && exp_mc != 32'hFFFF_FFFF) exp_mc = exp_mc + 1;
                $display("resolve pc=%08h pred=%0d taken=%0d mispredict=%0d redirect=%08h",
                         h.pc, h.pred, ex_taken, exp_mis, exp_redirect);
            end
            if (exp_mis) begin
                model_q.delete();
            end else begin
                if (fire) void'(model_q.pop_front());
                if (pushed) model_q.push_back('{push_pc, push_index, push_weight,
                                                push_pred, push_target});
            end
        end
        @(posedge clk);
        #1;
        check_val("update", {31'd0, update}, {31'd0, exp_update});
        check_val("update_index", 32'(update_index), exp_index);
        check_val("update_weight", 32'(update_weight), exp_weight);
        check_val("actual", {31'd0, actual}, {31'd0, exp_actual});
        check_val("mispredict", {31'd0, mispredict}, {31'd0, exp_mis});
        if (exp_mis || !exp_update) check_val("redirect_pc", redirect_pc, exp_redirect);
        check_val("underflow", {31'd0, underflow}, {31'd0, exp_underflow});
        check_val("branch_count", branch_count, exp_bc);
        check_val("mispredict_count", mispredict_count, exp_mc);
    endtask

    task automatic set_idle();
        push_valid = 1'b0;
        ex_valid   = 1'b0;
        ex_stall   = 1'b0;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
        push_valid  = 1'b1;
        push_pc     = pc;
        push_index  = bp_index_t'($urandom);
        push_weight = bp_weight_t'($urandom);
        push_pred   = pred;
        push_target = tgt;
    endtask

    task automatic set_resolve(input logic taken, input logic [31:0] tgt);
        ex_valid  = 1'b1;
        ex_stall  = 1'b0;
        ex_taken  = taken;
        ex_target = tgt;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        set_idle();
        step();
        step();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        set_idle();
        push_pc = '0; push_index = '0; push_weight = '0; push_pred = 1'b0; push_target = '0;
        ex_taken = 1'b0; ex_target = '0;
        do_reset();

        // Three correctly predicted branches resolve in order
        set_push(32'h1000, 1'b0, 32'h2000); step();
        set_push(32'h1004, 1'b1, 32'h3000); step();
        set_push(32'h1008, 1'b1, 32'h4000); step();
        set_idle(); set_resolve(1'b0, 32'h0);    step();
        set_idle(); set_resolve(1'b1, 32'h3000); step();
        set_idle(); set_resolve(1'b1, 32'h4000); step();
        check_val("bc_in_order", branch_count, 32'd3);
        set_idle(); step();

        // Taken branch to the wrong target
        set_push(32'h100, 1'b1, 32'h200); step();
        set_idle(); set_resolve(1'b1, 32'h240); step();
        check_val("redirect_wrong_target", redirect_pc, 32'h240);

        // Fall-through PC wraps past the top of memory
        set_push(32'hFFFF_FFFC, 1'b1, 32'h10); step();
        set_idle(); set_resolve(1'b0, 32'h0); step();
        check_val("redirect_wrap", redirect_pc, 32'h0);
        set_idle(); step();

        // Fill, drop on full, then simultaneous push and resolve
        for (int i = 0; i < 5; i++) begin
            set_push(32'h2000 + 32'(i * 4), 1'b0, 32'h0); step();
        end
        set_idle(); set_resolve(1'b0, 32'h0); step();
        set_push(32'h3000, 1'b0, 32'h0); set_resolve(1'b0, 32'h0); step();
        set_idle(); step();
        check_val("occupancy_after_push_pop", {31'd0, full}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            set_idle(); set_resolve(1'b0, 32'h0); step();
        end

        // Mispredict with younger entries and a concurrent push
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_push(32'h4000 + 32'(i * 4), 1'b0, 32'h0); step();
        end
        set_push(32'h5000, 1'b0, 32'h0); set_resolve(1'b1, 32'h8000); step();
        check_val("squash_mc", mispredict_count, 32'd1);

        // Resolve with nothing queued, sticky until reset
        set_idle(); set_resolve(1'b0, 32'h0); step();
        set_idle(); step(); step();
        check_val("underflow_sticky", {31'd0, underflow}, 32'd1);
        set_push(32'h6000, 1'b1, 32'h6100); step();
        set_push(32'h6004, 1'b1, 32'h6100); step();
        set_idle(); set_resolve(1'b1, 32'h6100);
        rstn = 1'b0; step();
        check_val("reset_update", {31'd0, update}, 32'd0);
        rstn = 1'b1;
        set_idle(); set_resolve(1'b0, 32'h0); step();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rstn        = ($urandom_range(0, 299) != 0);
            push_valid  = ($urandom_range(0, 99) < 55);
            push_pc     = $urandom & 32'hFFFF_FFFC;
            push_index  = bp_index_t'($urandom);
            push_weight = bp_weight_t'($urandom);
            push_pred   = 1'($urandom_range(0, 1));
            push_target = $urandom & 32'hFFFF_FFFC;
            ex_valid    = ($urandom_range(0, 99) < 45);
            ex_stall    = ($urandom_range(0, 99) < 20);
            if (model_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                ex_taken  = model_q[0].pred;
                ex_target = model_q[0].target;
            end else begin
                ex_taken  = 1'($urandom_range(0, 1));
                ex_target = $urandom;
            end
            step();
        end
        rstn = 1'b1;
        set_idle(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
